// File: rtl/cell_reduce_pipe_if.sv
// Handshake bundle for cell_reduce_pipe: N packed W-bit words plus op in, one W-bit word out.
interface cell_reduce_pipe_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
);
    logic [N*W-1:0] i;
    logic [1:0]     op;
    logic           i_valid;
    logic           i_ready;
    logic [W-1:0]   o;
    logic           o_valid;
    logic           o_ready;

    modport master (output i, op, i_valid, o_ready, input i_ready, o, o_valid);
    modport slave  (input i, op, i_valid, o_ready, output i_ready, o, o_valid);
endinterface

// File: rtl/cell_reduce_pipe.sv
// Pipelined N-word bitwise AND/OR/XOR/NAND reduction tree, registered every LPS levels,
// with a stall-on-full valid/ready handshake.
module cell_reduce_pipe #(
    parameter int unsigned N   = 8,
    parameter int unsigned W   = 1,
    parameter int unsigned LPS = 1
) (
    input logic               clk,
    input logic               reset,
    cell_reduce_pipe_if.slave bus
);
    localparam int unsigned L = (N > 1) ? $clog2(N) : 0;
    localparam int unsigned S = (L == 0) ? 1 : (L + LPS - 1) / LPS;
    localparam int unsigned P = 1 << L;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef logic [W-1:0] word_t;

    word_t       data_q [S][P];
    word_t       data_d [S][P];
    op_e         op_q   [S];
    logic [S-1:0] vld_q;

    word_t       cur [P];
    op_e         op_in;
    op_e         op_cur;
    int unsigned hi;
    int unsigned prev;
    logic        advance;

    function automatic word_t combine(op_e op, word_t a, word_t b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign op_in       = op_e'(bus.op);
    assign advance     = !vld_q[S-1] || bus.o_ready;
    assign bus.i_ready = advance;
    assign bus.o       = data_q[S-1][0];
    assign bus.o_valid = vld_q[S-1];

    // Each stage folds its levels in place: after level l, words [0, P>>(l+1)) hold the
    // partial results. NAND runs as AND and is inverted only on entry to the last register.
    always_comb begin
        cur    = '{default: '0};
        data_d = '{default: '{default: '0}};
        op_cur = OP_AND;
        hi     = 0;
        prev   = 0;
        for (int unsigned s = 0; s < S; s++) begin
            if (s == 0) begin
                op_cur = op_in;
                for (int unsigned k = 0; k < P; k++) begin
                    if (k < N) cur[k] = bus.i[k*W +: W];
                    else       cur[k] = (op_in == OP_OR || op_in == OP_XOR) ? '0 : '1;
                end
            end else begin
                prev   = s - 1;
                op_cur = op_q[prev];
                cur    = data_q[prev];
            end
            hi = ((s + 1) * LPS < L) ? (s + 1) * LPS : L;
            for (int unsigned l = s * LPS; l < hi; l++) begin
                for (int unsigned k = 0; k < (P >> (l + 1)); k++) begin
                    cur[k] = combine(op_cur, cur[2*k], cur[2*k+1]);
                end
            end
            if (s == S - 1 && op_cur == OP_NAND) cur[0] = ~cur[0];
            data_d[s] = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < S; s++) begin
                data_q[s] <= '{default: '0};
                op_q[s]   <= OP_AND;
            end
            vld_q <= '0;
        end else if (advance) begin
            data_q   <= data_d;
            op_q[0]  <= op_in;
            vld_q[0] <= bus.i_valid;
            for (int unsigned s = 1; s < S; s++) begin
                op_q[s]  <= op_q[s-1];
                vld_q[s] <= vld_q[s-1];
            end
        end
    end
endmodule

// File: tb/tb_cell_reduce_pipe.sv
// Bench for cell_reduce_pipe: four configurations checked by directed cases and a
// queue scoreboard fed from a plain word-by-word reduction model.
module tb_cell_reduce_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q0[$], q1[$], q2[$], q3[$];
    logic [3:0]  got4 [4];

    cell_reduce_pipe_if #(.N(8),  .W(4)) b8  ();
    cell_reduce_pipe_if #(.N(5),  .W(1)) b5  ();
    cell_reduce_pipe_if #(.N(1),  .W(1)) b1  ();
    cell_reduce_pipe_if #(.N(16), .W(4)) b16 ();

    cell_reduce_pipe #(.N(8),  .W(4), .LPS(1)) u8  (.clk(clk), .reset(rst), .bus(b8));
    cell_reduce_pipe #(.N(5),  .W(1), .LPS(1)) u5  (.clk(clk), .reset(rst), .bus(b5));
    cell_reduce_pipe #(.N(1),  .W(1), .LPS(1)) u1  (.clk(clk), .reset(rst), .bus(b1));
    cell_reduce_pipe #(.N(16), .W(4), .LPS(3)) u16 (.clk(clk), .reset(rst), .bus(b16));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_red(logic [1023:0] v, logic [1:0] op, int n, int w);
        logic [63:0] mask, acc, word;
        mask = (64'd1 << w) - 64'd1;
        acc  = (op == 2'd1 || op == 2'd2) ? 64'd0 : mask;
        for (int k = 0; k < n; k++) begin
            word = 64'(v >> (k * w)) & mask;
            case (op)
                2'd1:    acc = acc | word;
                2'd2:    acc = acc ^ word;
                default: acc = acc & word;
            endcase
        end
        if (op == 2'd3) acc = ~acc & mask;
        return acc;
    endfunction

    task automatic sb(int d, logic acc, logic ret, logic [63:0] e, logic [63:0] got);
        logic [63:0] front;
        int sz;
        case (d)
            0:       sz = q0.size();
            1:       sz = q1.size();
            2:       sz = q2.size();
            default: sz = q3.size();
        endcase
        if (ret) begin
            check($sformatf("sb%0d_pending", d), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                case (d)
                    0:       front = q0.pop_front();
                    1:       front = q1.pop_front();
                    2:       front = q2.pop_front();
                    default: front = q3.pop_front();
                endcase
                check($sformatf("sb%0d_data", d), got, front);
            end
        end
        if (acc) begin
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
        end else begin
            sb(0, b8.i_valid && b8.i_ready, b8.o_valid && b8.o_ready,
               ref_red(1024'(b8.i), b8.op, 8, 4), 64'(b8.o));
            sb(1, b5.i_valid && b5.i_ready, b5.o_valid && b5.o_ready,
               ref_red(1024'(b5.i), b5.op, 5, 1), 64'(b5.o));
            sb(2, b1.i_valid && b1.i_ready, b1.o_valid && b1.o_ready,
               ref_red(1024'(b1.i), b1.op, 1, 1), 64'(b1.o));
            sb(3, b16.i_valid && b16.i_ready, b16.o_valid && b16.o_ready,
               ref_red(1024'(b16.i), b16.op, 16, 4), 64'(b16.o));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b8.i_valid = 1'b0;  b8.o_ready = 1'b1;  b8.i = '0;  b8.op = 2'd0;
        b5.i_valid = 1'b0;  b5.o_ready = 1'b1;  b5.i = '0;  b5.op = 2'd0;
        b1.i_valid = 1'b0;  b1.o_ready = 1'b1;  b1.i = '0;  b1.op = 2'd0;
        b16.i_valid = 1'b0; b16.o_ready = 1'b1; b16.i = '0; b16.op = 2'd0;
    endtask

    initial begin
        int got_n, first, last, acc_n;
        logic [4:0] v5 [3];
        logic [1:0] op5 [3];
        logic       e5 [3];
        logic [3:0] e2 [4];

        v5[0] = 5'h1F; op5[0] = 2'd0; e5[0] = 1'b1;
        v5[1] = 5'h00; op5[1] = 2'd1; e5[1] = 1'b0;
        v5[2] = 5'h15; op5[2] = 2'd2; e5[2] = 1'b1;
        e2[0] = 4'h0; e2[1] = 4'hF; e2[2] = 4'hF; e2[3] = 4'hF;

        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_o_valid", 64'(b8.o_valid), 64'd0);
        check("rst_o",       64'(b8.o),       64'd0);
        check("rst_i_ready", 64'(b8.i_ready), 64'd1);
        check("rst_o_valid16", 64'(b16.o_valid), 64'd0);

        // Single AND transaction, S=3
        b8.i = 32'hFFEF_FFFF; b8.op = 2'd0; b8.i_valid = 1'b1;
        tick();
        b8.i_valid = 1'b0;
        check("t1_lat_e0", 64'(b8.o_valid), 64'd0);
        tick();
        check("t1_lat_e1", 64'(b8.o_valid), 64'd0);
        tick();
        check("t1_lat_e2", 64'(b8.o_valid), 64'd1);
        check("t1_data",   64'(b8.o),       64'hE);
        tick();
        check("t1_one_pulse", 64'(b8.o_valid), 64'd0);

        // Back-to-back AND, OR, XOR, NAND
        b8.i = 32'h0000_8421;
        got_n = 0; first = -1; last = -1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin b8.op = 2'(c); b8.i_valid = 1'b1; end
            else b8.i_valid = 1'b0;
            tick();
            if (b8.o_valid) begin
                if (got_n < 4) got4[got_n] = b8.o;
                if (got_n == 0) first = c;
                last = c;
                got_n++;
            end
        end
        check("t2_count", 64'(got_n), 64'd4);
        check("t2_first", 64'(first), 64'd2);
        check("t2_last",  64'(last),  64'd5);
        for (int k = 0; k < 4; k++) check($sformatf("t2_o%0d", k), 64'(got4[k]), 64'(e2[k]));

        // Backpressure: fill, stall 5 cycles, drain
        for (int c = 0; c < 4; c++) begin
            b8.i = $urandom; b8.op = 2'($urandom_range(0, 3)); b8.i_valid = 1'b1;
            tick();
        end
        b8.o_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            b8.i = $urandom; b8.op = 2'($urandom_range(0, 3));
            #1;
            check("t3_i_ready", 64'(b8.i_ready), 64'd0);
            check("t3_o_valid", 64'(b8.o_valid), 64'd1);
            check("t3_q_depth", 64'(q0.size()), 64'd3);
            if (q0.size() != 0) check("t3_o_hold", 64'(b8.o), q0[0]);
            tick();
        end
        b8.o_ready = 1'b1; b8.i_valid = 1'b0;
        for (int c = 0; c < 10 && (q0.size() != 0 || b8.o_valid); c++) tick();
        check("t3_drained", 64'(q0.size()), 64'd0);

        // N=5 padding cases
        for (int t = 0; t < 3; t++) begin
            b5.i = v5[t]; b5.op = op5[t]; b5.i_valid = 1'b1;
            tick();
            b5.i_valid = 1'b0;
            for (int c = 0; c < 8 && !b5.o_valid; c++) tick();
            check($sformatf("n5_valid%0d", t), 64'(b5.o_valid), 64'd1);
            check($sformatf("n5_o%0d", t),     64'(b5.o),       64'(e5[t]));
            tick();
        end

        // N=1 NAND passthrough, one register
        b1.i = 1'b1; b1.op = 2'd3; b1.i_valid = 1'b1;
        tick();
        b1.i_valid = 1'b0;
        check("n1_valid", 64'(b1.o_valid), 64'd1);
        check("n1_o",     64'(b1.o),       64'd0);
        tick();

        // N=16, LPS=3: S=2
        b16.i = {$urandom, $urandom}; b16.op = 2'($urandom_range(0, 3)); b16.i_valid = 1'b1;
        tick();
        b16.i_valid = 1'b0;
        check("n16_lat_e0", 64'(b16.o_valid), 64'd0);
        tick();
        check("n16_lat_e1", 64'(b16.o_valid), 64'd1);
        tick();

        acc_n = 0;
        for (int c = 0; c < 20000 && acc_n < 1000; c++) begin
            b16.i       = {$urandom, $urandom};
            b16.op      = 2'($urandom_range(0, 3));
            b16.i_valid = ($urandom_range(0, 3) != 0);
            b16.o_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b16.i_valid && b16.i_ready) acc_n++;
            tick();
        end
        b16.i_valid = 1'b0; b16.o_ready = 1'b1;
        for (int c = 0; c < 10 && (q3.size() != 0 || b16.o_valid); c++) tick();
        check("n16_accepted", 64'(acc_n), 64'd1000);
        check("n16_drained",  64'(q3.size()), 64'd0);

        // Reset with three transactions in flight
        for (int c = 0; c < 3; c++) begin
            b8.i = $urandom; b8.op = 2'($urandom_range(0, 3)); b8.i_valid = 1'b1;
            tick();
        end
        b8.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rb_o_valid", 64'(b8.o_valid), 64'd0);
        check("rb_o",       64'(b8.o),       64'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rb_stale%0d", c), 64'(b8.o_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cell_reduce_pipe.md
# cell_reduce_pipe

Parametrised, pipelined N-input bitwise reduction cell: the multi-input, multi-bit, multi-mode successor to the two-input AND standard-cell wrapper. It reduces N words of W bits to one W-bit word using AND, OR, XOR or NAND, selected per transaction. It inserts pipeline registers every LPS tree levels and exposes a valid/ready handshake. It sits in the stdcells library as the building block for wide enable/flag reductions that must close timing at high clock rates.

## Interface
- N, default 8: number of input words; legal 1..64.
- W, default 1: bits per word; legal 1..64.
- LPS, default 1: reduction-tree levels per pipeline stage; legal ≥1.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i  input  N*W  input words; word k occupies bits [k*W +: W].
- op  input  2  operation, sampled with i: 0 AND, 1 OR, 2 XOR, 3 NAND.
- i_valid  input  1  input transaction present.
- i_ready  output  1  block accepts the transaction this cycle.
- o  output  W  reduction result.
- o_valid  output  1  o holds a valid result.
- o_ready  input  1  downstream accepts o this cycle.

## Operation
- Tree depth L = ceil(log2(N)); number of register stages S = max(1, ceil(L/LPS)).
- Inputs are padded to 2^L words with the identity for the operation: all-ones for AND/NAND, zero for OR/XOR.
- NAND is computed as an AND tree. The final inversion is applied at the output register of the last stage, never per level.
- Each stage register holds partial results, a 2-bit op and a valid bit. op travels with the data, so different transactions in flight may use different operations.
- Stage s computes LPS tree levels, or the remaining levels in the last stage. N=1 passes the single word through one register, with inversion if NAND.
- Acceptance is i_valid && i_ready. An entry without acceptance writes valid=0 into stage 0 while the pipe advances.
- Stall: advance = !o_valid || o_ready. When advance=0, every stage holds data, op and valid. When advance=1, every stage shifts by one.
- i_ready = advance. It is combinational from o_ready and o_valid, with no combinational path from i_valid.
- Bubbles are not compressed; a stalled pipe holds them in place.
- o and o_valid are driven directly from the last stage register.

## Timing
- Reset: all stage valid bits 0, all stage data 0, o_valid=0, o=0, i_ready=1 in the cycle after reset deasserts.
- Reset while busy: all in-flight transactions are discarded, with no output pulse. Reset has priority over a concurrent accept or advance.
- Latency: a transaction accepted at edge t appears with o_valid=1 after edge t+S-1. It is visible during cycle t+S-1, or t+S counted from the accepting edge.
- Throughput is one transaction per cycle while o_ready=1.
- Holding: while o_valid && !o_ready, o and o_valid stay stable, and i_ready=0 in the same cycle.
- Simultaneous: o_valid && o_ready && i_valid in one cycle means the output retires and the input is accepted on the same edge.
- Width: all arithmetic is bitwise per lane. There is no carry and no cross-lane interaction; lane b of o depends only on lane b of each input.
- Padding words never reach o as data; they only hold identity values.

## Test plan
- Reset, then N=8, W=4, LPS=1 (S=3): apply i=all 0xF with word 5=0xE, op=AND, i_valid one cycle → o=0xE, o_valid high exactly 3 cycles after acceptance, for one cycle with o_ready=1.
- Back-to-back stream, o_ready=1: op sequence AND, OR, XOR, NAND on i words {0x1,0x2,0x4,0x8,0,0,0,0} → o = 0x0, 0xF, 0xF, 0xF in consecutive cycles.
- Backpressure: fill the pipe, then hold o_ready=0 for 5 cycles → o stable, i_ready=0, no transaction lost or duplicated; releasing o_ready drains in order.
- N=5, W=1 (padding case): all ones with AND → 1, all zeros with OR → 0, exactly three ones with XOR → 1. With N=1, i=1 and op=NAND → o=0 after 1 cycle.
- N=16, LPS=3 (L=4, S=2): latency exactly 2 cycles; randomised op and data compared against a reference model over 1000 transactions.
- Assert reset with 3 transactions in flight → next cycle o_valid=0 and o=0. After reset drops, no stale result appears within S+2 cycles.
